// File: rtl/key_history_matcher_if.sv
// Handshake and status bundle between the keystroke source and the history matcher.
// Master drives key codes and control; slave reports readiness, result and LED state.
interface key_history_matcher_if #(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 9
);
  localparam int FC_W = $clog2(DEPTH + 1);

  logic              code_valid;
  logic [CODE_W-1:0] code_in;
  logic              mode;
  logic              clear;
  logic              ready;
  logic              match;
  logic              done;
  logic [FC_W-1:0]   fill_count;
  logic              blink_o;

  modport master (
    output code_valid, code_in, mode, clear,
    input  ready, match, done, fill_count, blink_o
  );

  modport slave (
    input  code_valid, code_in, mode, clear,
    output ready, match, done, fill_count, blink_o
  );
endinterface

// File: rtl/key_history_matcher.sv
// Keeps the last DEPTH key codes and checks them for a repeat or palindrome pattern,
// one pair per cycle, reporting a sticky match flag and a status LED blink.
module key_history_matcher #(
  parameter int DEPTH     = 16,
  parameter int CODE_W    = 9,
  parameter int BLINK_DIV = 6250000
) (
  input logic                  Clock_50,
  input logic                  Reset,
  key_history_matcher_if.slave bus
);
  localparam int HALF  = DEPTH / 2;
  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam int WIN_W = $clog2(DEPTH);
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [DEPTH-1:0][CODE_W-1:0] win_q, win_d;
  logic [FC_W-1:0]              fill_q, fill_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         mode_q, mode_d;
  logic                         result_q, result_d;
  logic                         match_q, match_d;
  logic                         done_q, done_d;
  logic                         blink_q, blink_d;
  logic [BC_W-1:0]              bcnt_q, bcnt_d;
  logic [WIN_W-1:0]             ia, ib;
  logic                         pair_eq;

  // Partner of w[idx]: second half for REPEAT, mirrored slot for PALINDROME.
  always_comb begin
    ia      = WIN_W'(idx_q);
    ib      = mode_q ? (WIN_W'(DEPTH - 1) - WIN_W'(idx_q)) : (WIN_W'(idx_q) + WIN_W'(HALF));
    pair_eq = (win_q[ia] == win_q[ib]);
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    result_d = result_q;
    match_d  = match_q;
    done_d   = 1'b0;
    if (bus.clear) begin
      state_d = S_IDLE;
      win_d   = '0;
      fill_d  = '0;
      idx_d   = '0;
      match_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.code_valid) begin
            win_d = {win_q[DEPTH-2:0], bus.code_in};
            if (fill_q != FC_W'(DEPTH)) fill_d = fill_q + 1'b1;
            if (fill_q >= FC_W'(DEPTH - 1)) begin
              state_d = S_COMPARE;
              mode_d  = bus.mode;
              idx_d   = '0;
            end else begin
              match_d = 1'b0;
            end
          end
        end
        S_COMPARE: begin
          if (!pair_eq) begin
            result_d = 1'b0;
            state_d  = S_RESULT;
          end else if (idx_q == IDX_W'(HALF - 1)) begin
            result_d = 1'b1;
            state_d  = S_RESULT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_RESULT: begin
          match_d = result_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counting starts the cycle after match rises so the first toggle lands BLINK_DIV cycles later.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (!match_d) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (match_q) begin
      if (bcnt_q == BC_W'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      fill_q   <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= 1'b0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      fill_q   <= fill_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      match_q  <= match_d;
      done_q   <= done_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.match      = match_q;
  assign bus.done       = done_q;
  assign bus.fill_count = fill_q;
  assign bus.blink_o    = blink_q;
endmodule

// File: tb/tb_key_history_matcher.sv
// Randomized and directed checks of key_history_matcher (DEPTH=4, BLINK_DIV=4)
// against a window/pair model kept in the bench.
module tb_key_history_matcher;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [8:0] wm [D];
  int         mfill;
  logic       mmatch;

  key_history_matcher_if #(.DEPTH(D), .CODE_W(9)) bus ();

  key_history_matcher #(.DEPTH(D), .CODE_W(9), .BLINK_DIV(4)) dut (
    .Clock_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) wm[i] = '0;
    mfill  = 0;
    mmatch = 1'b0;
  endfunction

  function automatic void model_push(input logic [8:0] c);
    for (int i = D - 1; i > 0; i--) wm[i] = wm[i-1];
    wm[0] = c;
    if (mfill < D) mfill++;
  endfunction

  // n = pairs examined before the verdict, r = verdict.
  function automatic void model_eval(input logic m, output int n, output bit r);
    r = 1'b1;
    n = D / 2;
    for (int i = 0; i < D / 2; i++) begin
      int j;
      j = m ? (D - 1 - i) : (i + D / 2);
      if (wm[i] != wm[j]) begin
        r = 1'b0;
        n = i + 1;
        break;
      end
    end
  endfunction

  task automatic drive_push(input logic [8:0] c, input logic m);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: ready=%b wanted 1", bus.ready);
    end
    bus.code_valid = 1'b1;
    bus.code_in    = c;
    bus.mode       = m;
    @(posedge clk);
    #1 bus.code_valid = 1'b0;
    model_push(c);
  endtask

  task automatic push_check(input logic [8:0] c, input logic m);
    int n, busy, dcyc, dones;
    bit r;
    drive_push(c, m);
    if (mfill < D) begin
      mmatch = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.ready, bus.match, bus.done, bus.fill_count} !== {1'b1, 1'b0, 1'b0, 3'(mfill)}) begin
        bad++;
        $display("FAIL partial_push: rdy=%b match=%b done=%b fill=%0d wanted 1 0 0 %0d",
                 bus.ready, bus.match, bus.done, bus.fill_count, mfill);
      end
    end else begin
      model_eval(m, n, r);
      busy = 0; dcyc = -1; dones = 0;
      for (int j = 0; j < D + 4; j++) begin
        @(negedge clk);
        if (!bus.ready) busy++;
        if (bus.done) begin
          dones++;
          if (dcyc < 0) dcyc = j;
        end
      end
      total++;
      if (busy != n + 1) begin
        bad++; $display("FAIL busy_cycles: got %0d wanted %0d", busy, n + 1);
      end
      total++;
      if (dcyc != n + 1 || dones != 1) begin
        bad++; $display("FAIL done_pulse: at %0d count %0d wanted at %0d count 1", dcyc, dones, n + 1);
      end
      total++;
      if (bus.match !== r || bus.fill_count !== 3'(D)) begin
        bad++; $display("FAIL eval_result: match=%b fill=%0d wanted %b %0d", bus.match, bus.fill_count, r, D);
      end
      mmatch = r;
    end
  endtask

  task automatic clear_window();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.code_valid = 1'b0; bus.code_in = '0; bus.mode = 1'b0; bus.clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ready, bus.match, bus.done, bus.fill_count, bus.blink_o} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%b match=%b done=%b fill=%0d blink=%b wanted 1 0 0 0 0",
               bus.ready, bus.match, bus.done, bus.fill_count, bus.blink_o);
    end
  endtask

  task automatic test_fill_up();
    clear_window();
    push_check(9'h01C, 1'b0);
    push_check(9'h032, 1'b0);
    push_check(9'h01C, 1'b0);
  endtask

  task automatic test_repeat_hit();
    push_check(9'h032, 1'b0);
    total++;
    if (bus.match !== 1'b1) begin
      bad++; $display("FAIL repeat_hit: match=%b wanted 1", bus.match);
    end
  endtask

  task automatic test_early_mismatch();
    clear_window();
    push_check(9'h015, 1'b1);
    push_check(9'h01D, 1'b1);
    push_check(9'h024, 1'b1);
    push_check(9'h02D, 1'b1);
  endtask

  task automatic test_palindrome_shift();
    clear_window();
    push_check(9'h11C, 1'b1);
    push_check(9'h032, 1'b1);
    push_check(9'h032, 1'b1);
    push_check(9'h11C, 1'b1);
    total++;
    if (bus.match !== 1'b1) begin
      bad++; $display("FAIL palindrome_hit: match=%b wanted 1", bus.match);
    end
    push_check(9'h021, 1'b1);
    total++;
    if (bus.match !== 1'b0) begin
      bad++; $display("FAIL palindrome_break: match=%b wanted 0", bus.match);
    end
  endtask

  task automatic test_blink();
    int k, errs;
    clear_window();
    drive_push(9'h01C, 1'b0);
    drive_push(9'h032, 1'b0);
    drive_push(9'h01C, 1'b0);
    drive_push(9'h032, 1'b0);
    k = 0;
    @(negedge clk);
    while (!bus.match && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!bus.match) begin
      bad++; $display("FAIL blink_match_timeout: match=%b wanted 1", bus.match);
    end
    errs = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.blink_o !== (((j / 4) % 2) == 1)) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL blink_period: %0d wrong cycles wanted 0", errs);
    end
    clear_window();
    @(negedge clk);
    total++;
    if ({bus.match, bus.blink_o, bus.fill_count} !== {1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL blink_clear: match=%b blink=%b fill=%0d wanted 0 0 0", bus.match, bus.blink_o, bus.fill_count);
    end
  endtask

  task automatic test_abort();
    int dones;
    clear_window();
    drive_push(9'h01C, 1'b0);
    drive_push(9'h032, 1'b0);
    drive_push(9'h01C, 1'b0);
    drive_push(9'h032, 1'b0);
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code_in    = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.fill_count !== 3'(D) || bus.ready !== 1'b0) begin
      bad++; $display("FAIL busy_ignore: fill=%0d rdy=%b wanted %0d 0", bus.fill_count, bus.ready, D);
    end
    bus.code_valid = 1'b0;
    bus.clear      = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if ({bus.ready, bus.fill_count, bus.match} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL abort_state: rdy=%b fill=%0d match=%b wanted 1 0 0", bus.ready, bus.fill_count, bus.match);
    end
    dones = bus.done ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_done: %0d pulses wanted 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] cs [4];
    int n, k, errs;
    bit r;
    cs[0] = 9'h01C; cs[1] = 9'h032; cs[2] = 9'h01C; cs[3] = 9'h032;
    clear_window();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.code_valid = 1'b1;
      bus.code_in    = cs[i];
      bus.mode       = 1'b0;
      @(posedge clk);
      model_push(cs[i]);
      @(negedge clk);
      total++;
      if (bus.fill_count !== 3'(i + 1) || bus.ready !== 1'b1) begin
        bad++; $display("FAIL back_to_back_fill: fill=%0d rdy=%b wanted %0d 1", bus.fill_count, bus.ready, i + 1);
      end
    end
    bus.code_in = cs[3];
    @(posedge clk);
    model_push(cs[3]);
    model_eval(1'b0, n, r);
    k = 0; errs = 0;
    @(negedge clk);
    while (!bus.ready && k < 20) begin
      if (bus.fill_count !== 3'(D)) errs++;
      @(negedge clk);
      k++;
    end
    bus.code_valid = 1'b0;
    total++;
    if (!bus.ready || k != n + 1 || errs != 0) begin
      bad++; $display("FAIL held_valid_busy: rdy=%b busy=%0d fillerr=%0d wanted 1 %0d 0", bus.ready, k, errs, n + 1);
    end
    total++;
    if (bus.match !== r) begin
      bad++; $display("FAIL held_valid_match: match=%b wanted %b", bus.match, r);
    end
    mmatch = r;
    push_check(9'h01C, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_window();
    push_check(9'h01C, 1'b0);
    push_check(9'h032, 1'b0);
    push_check(9'h01C, 1'b0);
    push_check(9'h032, 1'b0);
    drive_push(9'h01C, 1'b0);
    @(negedge clk);
    total++;
    if (bus.ready !== 1'b0 || bus.match !== 1'b1) begin
      bad++; $display("FAIL pre_reset_busy: rdy=%b match=%b wanted 0 1", bus.ready, bus.match);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.ready, bus.match, bus.done, bus.fill_count, bus.blink_o} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: rdy=%b match=%b done=%b fill=%0d blink=%b wanted 1 0 0 0 0",
               bus.ready, bus.match, bus.done, bus.fill_count, bus.blink_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [8:0] alpha [3];
    alpha[0] = 9'h01C; alpha[1] = 9'h032; alpha[2] = 9'h11C;
    for (int i = 0; i < 40; i++)
      push_check(alpha[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_fill_up();
    test_repeat_hit();
    test_early_mismatch();
    test_palindrome_shift();
    test_blink();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_history_matcher.md
# key_history_matcher

Parametrised keystroke-history pattern detector that sits between the PS2 controller/ROM path and the LCD/LED logic in the keyboard-to-LCD design. It keeps the last DEPTH accepted key codes (shift flag plus scan code) in a shift window. On each accepted code, once the window is full, it runs a sequential pair-compare state machine in the selected mode: repeat (second half equals first half) or palindrome. The result drives a sticky match flag and a blink output for a status LED.

## Interface
- DEPTH, 16, window length in codes; must be even and ≥ 2.
- CODE_W, 9, code width; default is {shift_key, PS2_code[7:0]}.
- BLINK_DIV, 6250000, clock cycles per blink_o half-period.
- Clock_50  input  1  single clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- code_valid  input  1  offer code_in; accepted when code_valid & ready at a rising edge.
- code_in  input  CODE_W  key code to push.
- mode  input  1  0 = REPEAT, 1 = PALINDROME; sampled at acceptance.
- clear  input  1  flush window and abort any evaluation.
- ready  output  1  high only in S_IDLE.
- match  output  1  result of last completed evaluation.
- done  output  1  one-cycle pulse when an evaluation completes.
- fill_count  output  $clog2(DEPTH+1)  valid entries, saturating at DEPTH.
- blink_o  output  1  LED blink while match is 1.

## Operation
- Window w[0..DEPTH-1]; w[0] is newest. A push moves w[i] to w[i+1], discards w[DEPTH-1] and loads w[0] with code_in.
- fill_count increments on each push and saturates at DEPTH.
- Pair i, for i = 0..DEPTH/2-1, compares:
  - REPEAT: w[i] vs w[i+DEPTH/2].
  - PALINDROME: w[i] vs w[DEPTH-1-i].
- The compared pair index has width max(1, $clog2(DEPTH/2)).
- FSM states: S_IDLE, S_COMPARE, S_RESULT.
- S_IDLE:
  - clear has priority over code_valid: window zeroed, fill_count=0, match=0, no done.
  - On an accepted push, if the post-push fill_count equals DEPTH: latch mode, set idx=0, go to S_COMPARE.
  - On an accepted push that leaves the window not full: match<=0, no done, stay in S_IDLE.
- S_COMPARE:
  - Each cycle, compare pair idx.
  - Mismatch: result=0, go to S_RESULT.
  - Equal and idx = DEPTH/2-1: result=1, go to S_RESULT.
  - Otherwise idx++.
- S_RESULT: match<=result, done=1 for this cycle, go to S_IDLE.
- clear in S_COMPARE or S_RESULT:
  - Go to S_IDLE, zero the window, fill_count=0, match=0.
  - No done pulse, and no push occurs that cycle.
- code_valid while ready=0 is ignored. The upstream must hold the code or drop it; this block never buffers it.
- Blink:
  - Divider counts 0..BLINK_DIV-1 while match=1; blink_o toggles at each wrap.
  - When match=0: counter=0, blink_o=0.
  - The first toggle occurs BLINK_DIV cycles after match rises.

## Timing
- Reset values: ready=1, match=0, done=0, fill_count=0, blink_o=0, window all zeros, state S_IDLE, idx=0.
- Reset is asynchronous in both directions; asserting it mid-evaluation discards all state immediately.
- Push accepted at edge T, window full: ready=0 from T.
- With N = pairs compared (1..DEPTH/2):
  - Compares occur at edges T+1..T+N.
  - match updates and done is high during the cycle after edge T+N+1.
  - ready returns high after edge T+N+1.
- Worst-case busy time is DEPTH/2+1 cycles; an immediate mismatch gives 2 cycles.
- Push accepted at edge T, window not full: match=0 after T, ready stays 1, so back-to-back pushes are allowed.
- match is held between evaluations; a new evaluation overwrites it only in S_RESULT.
- fill_count saturation: a push at DEPTH keeps it at DEPTH, and every later push evaluates.

## Test plan
- Fill-up: DEPTH=4, REPEAT; push 0x01C, 0x032, 0x01C → fill_count 1,2,3; ready stays 1; match=0; no done.
- Repeat hit: DEPTH=4, REPEAT; push 0x01C, 0x032, 0x01C, 0x032 → after the 4th push ready=0 for 3 cycles; done pulses once; match=1.
- Early mismatch: DEPTH=4, PALINDROME; push 0x015, 0x01D, 0x024, 0x02D → done 2 cycles after acceptance; match=0.
- Palindrome with shift codes: DEPTH=4; push 0x11C, 0x032, 0x032, 0x11C → match=1. A further push of 0x021 → match=0 after its evaluation.
- Blink: BLINK_DIV=4 with match=1 → blink_o toggles every 4 cycles; a clear pulse → match=0, blink_o=0 next cycle, fill_count=0.
- Abort and reset:
  - clear asserted during S_COMPARE → no done; ready=1 next cycle; code_valid while ready=0 leaves fill_count unchanged.
  - Reset asserted mid-compare → all outputs take reset values asynchronously.
